// File: rtl/ct_vfdsu_wb_buf.sv
// Writeback buffer for the vector FP divide/sqrt unit: a small FIFO that
// holds completed results (data, flags, vreg/ereg, iid) until the shared
// VFPU writeback port grants, back-pressures the divider when full and
// drops everything on a pipeline flush.
module ct_vfdsu_wb_buf #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64,
  parameter int PTR_W  = 1
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              rtu_yy_xx_flush,
  input  logic              vfdsu_wb_vld,
  input  logic [DATA_W-1:0] vfdsu_wb_data,
  input  logic [4:0]        vfdsu_wb_expt,
  input  logic [6:0]        vfdsu_wb_vreg,
  input  logic [4:0]        vfdsu_wb_ereg,
  input  logic [6:0]        vfdsu_wb_iid,
  input  logic              wb_vfdsu_grant,
  output logic              wb_buf_req,
  output logic [DATA_W-1:0] wb_buf_data,
  output logic [4:0]        wb_buf_expt,
  output logic [6:0]        wb_buf_vreg,
  output logic [4:0]        wb_buf_ereg,
  output logic [6:0]        wb_buf_iid,
  output logic              wb_buf_stall,
  output logic              wb_buf_empty,
  output logic              wb_buf_ovfl
);

  localparam int             ENT_W = DATA_W + 24;
  localparam logic [PTR_W:0] FULL  = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             ovfl;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] entry [DEPTH];
  logic [ENT_W-1:0] head;

  // A full buffer still accepts a result when the head leaves in the same cycle.
  assign pop  = wb_buf_req & wb_vfdsu_grant;
  assign push = vfdsu_wb_vld & ((cnt != FULL) | pop);

  // Pointer and occupancy control; flush wins over any push/pop that cycle.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (rtu_yy_xx_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky overflow: a result arrived with no room and nothing leaving.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ovfl <= 1'b0;
    end else if (vfdsu_wb_vld && (cnt == FULL) && !pop) begin
      ovfl <= 1'b1;
    end
  end

  // Payload storage is not reset; only valid entries are ever presented.
  always_ff @(posedge forever_cpuclk) begin
    if (push && !rtu_yy_xx_flush) begin
      entry[wr_ptr] <= {vfdsu_wb_data, vfdsu_wb_expt, vfdsu_wb_vreg,
                        vfdsu_wb_ereg, vfdsu_wb_iid};
    end
  end

  assign head         = entry[rd_ptr];
  assign wb_buf_data  = head[ENT_W-1:24];
  assign wb_buf_expt  = head[23:19];
  assign wb_buf_vreg  = head[18:12];
  assign wb_buf_ereg  = head[11:7];
  assign wb_buf_iid   = head[6:0];
  assign wb_buf_req   = (cnt != '0);
  assign wb_buf_empty = (cnt == '0);
  assign wb_buf_stall = (cnt == FULL);
  assign wb_buf_ovfl  = ovfl;

endmodule

// File: tb/tb_ct_vfdsu_wb_buf.sv
// Self-checking bench for ct_vfdsu_wb_buf: directed scenarios followed by
// random traffic, compared against a queue-based model of the buffer.
module tb_ct_vfdsu_wb_buf;

  localparam int DEPTH  = 2;
  localparam int DATA_W = 64;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  expt;
    logic [6:0]  vreg;
    logic [4:0]  ereg;
    logic [6:0]  iid;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush, vld, grant;
  res_t in_res;
  logic req, stall, empty, ovfl_o;
  logic [63:0] o_data;
  logic [4:0]  o_expt, o_ereg;
  logic [6:0]  o_vreg, o_iid;

  res_t model_q[$];
  logic model_ovfl;
  int   tests = 0;
  int   fails = 0;
  int   seen_iid[$];

  always #5 clk = ~clk;

  ct_vfdsu_wb_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PTR_W(1)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .rtu_yy_xx_flush(flush),
    .vfdsu_wb_vld   (vld),
    .vfdsu_wb_data  (in_res.data),
    .vfdsu_wb_expt  (in_res.expt),
    .vfdsu_wb_vreg  (in_res.vreg),
    .vfdsu_wb_ereg  (in_res.ereg),
    .vfdsu_wb_iid   (in_res.iid),
    .wb_vfdsu_grant (grant),
    .wb_buf_req     (req),
    .wb_buf_data    (o_data),
    .wb_buf_expt    (o_expt),
    .wb_buf_vreg    (o_vreg),
    .wb_buf_ereg    (o_ereg),
    .wb_buf_iid     (o_iid),
    .wb_buf_stall   (stall),
    .wb_buf_empty   (empty),
    .wb_buf_ovfl    (ovfl_o)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t rand_res();
    res_t r;
    r.data = {$urandom, $urandom};
    r.expt = 5'($urandom);
    r.vreg = 7'($urandom);
    r.ereg = 5'($urandom);
    r.iid  = 7'($urandom);
    return r;
  endfunction

  // Compare all observable outputs against the model queue.
  task automatic check_outputs(input string tag);
    res_t head;
    check({tag, ".req"},   128'(req),    128'(model_q.size() != 0));
    check({tag, ".empty"}, 128'(empty),  128'(model_q.size() == 0));
    check({tag, ".stall"}, 128'(stall),  128'(model_q.size() == DEPTH));
    check({tag, ".ovfl"},  128'(ovfl_o), 128'(model_ovfl));
    if (model_q.size() != 0) begin
      head = model_q[0];
      check({tag, ".head"}, 128'({o_data, o_expt, o_vreg, o_ereg, o_iid}), 128'(head));
    end
  endtask

  // One clock of stimulus: the model applies the buffer's rules, then outputs are checked.
  task automatic cycle(input string tag, input logic v, input res_t r,
                       input logic g, input logic f);
    bit do_pop, do_push;
    vld = v; in_res = r; grant = g; flush = f;
    do_pop  = (model_q.size() != 0) && g;
    do_push = v && ((model_q.size() < DEPTH) || do_pop);
    if (v && !do_push) model_ovfl = 1'b1;
    if (f) begin
      model_q.delete();
    end else begin
      if (do_pop) begin
        seen_iid.push_back(int'(model_q[0].iid));
        void'(model_q.pop_front());
      end
      if (do_push) model_q.push_back(r);
    end
    @(posedge clk);
    #1;
    vld = 1'b0; grant = 1'b0; flush = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    res_t a, b, c, s;
    rst_n = 1'b0; flush = 1'b0; vld = 1'b0; grant = 1'b0; in_res = '0;
    model_ovfl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single result passes straight through with grant held.
    s = '{data: 64'h3FF0000000000000, expt: 5'h01, vreg: 7'd5, ereg: 5'd3, iid: 7'h12};
    cycle("single_push", 1'b1, s, 1'b1, 1'b0);
    check("single_iid", 128'(o_iid), 128'(7'h12));
    cycle("single_pop", 1'b0, '0, 1'b1, 1'b0);

    // Fill, then overflow attempt.
    a = rand_res(); a.iid = 7'd10;
    b = rand_res(); b.iid = 7'd11;
    c = rand_res(); c.iid = 7'd12;
    cycle("fill_a", 1'b1, a, 1'b0, 1'b0);
    cycle("fill_b", 1'b1, b, 1'b0, 1'b0);
    cycle("ovfl",   1'b1, rand_res(), 1'b0, 1'b0);
    check("ovfl_set", 128'(ovfl_o), 128'(1'b1));

    // Push and pop at capacity: order A, B, C.
    seen_iid.delete();
    cycle("full_pp", 1'b1, c, 1'b1, 1'b0);
    cycle("drain_b", 1'b0, '0, 1'b1, 1'b0);
    cycle("drain_c", 1'b0, '0, 1'b1, 1'b0);
    check("order_n", 128'(seen_iid.size()), 128'(3));
    if (seen_iid.size() == 3)
      check("order_abc", 128'({seen_iid[0], seen_iid[1], seen_iid[2]}), 128'({32'd10, 32'd11, 32'd12}));

    // Pointer wrap with iids 1..5.
    seen_iid.delete();
    for (int i = 1; i <= 5; i++) begin
      s = rand_res(); s.iid = 7'(i);
      cycle("wrap_push", 1'b1, s, 1'b0, 1'b0);
      cycle("wrap_pop",  1'b0, '0, 1'b1, 1'b0);
    end
    check("wrap_n", 128'(seen_iid.size()), 128'(5));
    for (int i = 0; i < seen_iid.size(); i++)
      check("wrap_iid", 128'(seen_iid[i]), 128'(i + 1));

    // Flush overrides simultaneous push and pop.
    cycle("fl_pre", 1'b1, rand_res(), 1'b0, 1'b0);
    cycle("flush",  1'b1, rand_res(), 1'b1, 1'b1);
    check("flush_req", 128'(req), 128'(1'b0));
    cycle("fl_post", 1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-operation with one entry held.
    cycle("rst_pre", 1'b1, rand_res(), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_q.delete();
    model_ovfl = 1'b0;
    check_outputs("async_rst");
    #1 rst_n = 1'b1;
    s = rand_res();
    cycle("post_rst_push", 1'b1, s, 1'b0, 1'b0);
    cycle("post_rst_pop",  1'b0, '0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), rand_res(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety bound in case the stimulus stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ct_vfdsu_wb_buf.md
Name: ct_vfdsu_wb_buf

Overview:
Result writeback buffer directly downstream of the vector FP divide/sqrt unit. Captures each completed divide/sqrt result (freg data, exception flags, destination vreg/ereg, iid) on the divider's completion pulse. Holds results in a small FIFO until the shared VFPU writeback port grants. Back-pressures the divider when full and discards all entries on pipeline flush.

Parameters:
DEPTH, 2, number of result entries (power of two, >=2)
DATA_W, 64, result data width
PTR_W, 1, log2(DEPTH)

Ports:
forever_cpuclk  in  1  free-running clock
cpurst_b  in  1  async active-low reset
rtu_yy_xx_flush  in  1  pipeline flush; empties buffer
vfdsu_wb_vld  in  1  divider result valid (one-cycle pulse per result)
vfdsu_wb_data  in  DATA_W  result data
vfdsu_wb_expt  in  5  exception flags (NV,DZ,OF,UF,NX)
vfdsu_wb_vreg  in  7  destination vreg
vfdsu_wb_ereg  in  5  destination ereg
vfdsu_wb_iid  in  7  instruction id
wb_vfdsu_grant  in  1  writeback port grant for current head
wb_buf_req  out  1  head entry valid, requesting writeback
wb_buf_data  out  DATA_W  head data
wb_buf_expt  out  5  head flags
wb_buf_vreg  out  7  head vreg
wb_buf_ereg  out  5  head ereg
wb_buf_iid  out  7  head iid
wb_buf_stall  out  1  buffer full; divider must hold its result
wb_buf_empty  out  1  no valid entries (debug idle)
wb_buf_ovfl  out  1  sticky: push attempted while full and not popping

Behaviour:
- Both ports: clock forever_cpuclk; reset cpurst_b is asynchronous and active-low.
- State: wr_ptr, rd_ptr (PTR_W bits, wrap modulo DEPTH), cnt (PTR_W+1 bits), entry array, ovfl flag.
- Reset: pointers=0, cnt=0, ovfl=0. Outputs: wb_buf_req=0, wb_buf_stall=0, wb_buf_empty=1, wb_buf_ovfl=0. Head payload outputs are don't-care while req=0. Entry array is not reset.
- push = vfdsu_wb_vld & (cnt!=DEPTH | pop).
- pop = wb_buf_req & wb_vfdsu_grant.
- Push writes the entry at wr_ptr and advances wr_ptr. Pop advances rd_ptr.
- cnt update: +1 on push only; -1 on pop only; unchanged on both or neither.
- Push while full with simultaneous pop is accepted (pass-through at capacity).
- Outputs (combinational from registers):
  - wb_buf_req = (cnt!=0).
  - Head payload = entry[rd_ptr].
  - wb_buf_stall = (cnt==DEPTH).
  - wb_buf_empty = (cnt==0).
- Latency: a result pushed in cycle N raises wb_buf_req in N+1 if the buffer was empty. There is no same-cycle bypass.
- Grant when req=0 is ignored.
- Overflow: vfdsu_wb_vld while cnt==DEPTH and no pop. Data is dropped, state is unchanged, ovfl is set. ovfl clears only on reset.
- Flush: rtu_yy_xx_flush=1 forces pointers=0 and cnt=0 next cycle. It overrides push and pop in the same cycle; no entry survives. ovfl is unaffected.
- Head order is strict FIFO. Grant can only pop the head.

Test Plan:
- Reset mid-operation: reset with cnt=1 -> req=0, empty=1, stall=0 immediately (asynchronous). After release the first push is stored at entry 0.
- Single result: vld with data=0x3FF0000000000000, expt=0x01, vreg=5, ereg=3, iid=0x12 at cycle N, grant held 1 -> req=1 at N+1 with identical payload; at N+2 req=0, empty=1.
- Fill and back-pressure: two pushes with grant=0 -> stall=1 after the second push. Third vld with grant=0 -> ovfl=1, cnt stays 2, head data unchanged.
- Push+pop when full: cnt=2, vld and grant in the same cycle -> cnt stays 2. Head advances to the second entry; the new entry is readable after one further pop. Order preserved: A, B, C.
- Pointer wrap: 5 sequential push/pop pairs with distinct iids 1..5 -> outputs appear in order 1..5 with no loss across the wrap of rd_ptr/wr_ptr.
- Flush priority: cnt=1, same cycle vld=1, grant=1, flush=1 -> next cycle cnt=0, req=0. The pushed result never appears on the output.
